board_input_conditioner: RTL and testbench
==========================================

// Module: board_input_conditioner
// PURPOSE
//  Conditions raw board switches/buttons before they reach the pipeline control board.
//  Per-bit 2-flop synchronizer, debounce filter, and registered one-cycle button press
//  pulses. Feeds clean switches/buttons levels plus press pulses to the control board.
//  Sits directly upstream of the control board; one clock domain.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive synced cycles an input must differ before accepted (>=1)
//  REPEAT_CYCLES    8   auto-repeat period in cycles (used only with AUTOREPEAT_EN, >=2)
//  N_SW             4   number of switch inputs
//  N_BTN            3   number of button inputs
// PORTS
//  clk            in   1      system clock, rising edge
//  reset_n        in   1      asynchronous active-low reset
//  switches_raw   in   N_SW   raw switch levels, asynchronous to clk
//  buttons_raw    in   N_BTN  raw button levels, asynchronous to clk, 1 = pressed
//  switches       out  N_SW   debounced switch levels
//  buttons        out  N_BTN  debounced button levels
//  button_pulse   out  N_BTN  one-cycle pulse per accepted press (0->1 of buttons)
//  input_changed  out  1      one-cycle pulse when any debounced switch/button bit changes
// BEHAVIOUR
//  - Reset (reset_n=0, async): sync flops, stable levels, counters, all outputs -> 0.
//    Release is sampled on next clk edge; no output changes before a full filter run.
//  - Sync: raw -> s1 -> s2 per bit; s2 is the only value the filter observes.
//  - Filter per bit: cnt width $clog2(DEBOUNCE_CYCLES)+1, saturating, never wraps.
//    s2 == stable: cnt <= 0.  s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//    s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
//  - Latency: raw step held steady changes output on the (2+DEBOUNCE_CYCLES)th rising
//    edge after the step (edge 6 at default). Any return to old value restarts count.
//  - Glitch shorter than DEBOUNCE_CYCLES synced cycles: no output change, no pulse.
//  - button_pulse[i]: registered, high exactly the cycle buttons[i] first reads 1;
//    release (1->0) never pulses. Held button: single pulse (see CONFIGURATION).
//  - input_changed: registered, high the cycle any switches/buttons bit differs from
//    its previous value; simultaneous changes on several bits give one single-cycle pulse.
//  - Bits are independent: different bits may update on the same or different edges.
//  - Reset mid-count: counter and partial progress discarded; full latency applies again.
//  - switches/buttons are levels: hold until a new value is accepted; no handshake.
// CONFIGURATION
//  AUTOREPEAT_EN defined: per-button repeat counter, cleared on initial press pulse;
//    while buttons[i] stays 1 it counts, and when it reaches REPEAT_CYCLES button_pulse[i]
//    fires again and counter clears -> pulses every REPEAT_CYCLES cycles while held.
//    Release clears counter immediately; input_changed not raised by repeats.
//  AUTOREPEAT_EN undefined: no repeat counters synthesized; exactly one pulse per press;
//    REPEAT_CYCLES ignored.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
//  1. reset_n=0 with all raw=1 -> all outputs 0; release, switches_raw=4'b1000 held ->
//     switches=4'b1000 on edge 6 after step, input_changed high exactly 1 cycle.
//  2. buttons_raw=3'b010 for 3 cycles then 3'b000 -> buttons stays 3'b000, no
//     button_pulse, no input_changed.
//  3. buttons_raw=3'b110 held 10 cycles -> buttons=3'b110 on edge 6, button_pulse=3'b110
//     one cycle; then 3'b000 held -> buttons=3'b000 after 6 edges, button_pulse stays 0.
//  4. buttons_raw[0]=1 for 3 cycles, reset_n pulsed low -> outputs 0; after release with
//     raw still 1, buttons[0] rises only 6 edges after first post-reset edge.
//  5. switches_raw=4'b0001 and buttons_raw=3'b001 stepped same cycle -> both outputs
//     update same edge, single input_changed pulse, button_pulse=3'b001.
//  6. AUTOREPEAT_EN: buttons_raw=3'b100 held 30 cycles -> button_pulse[2] at press edge t,
//     t+8, t+16, t+24; without macro only at t.

Source files
------------

// File: rtl/board_input_conditioner.sv
// board_input_conditioner
//   Cleans up raw board switches and buttons before they reach the pipeline
//   control board. Each raw bit passes through a 2-flop synchronizer and then
//   a saturating debounce filter. The filter publishes clean levels, one-cycle
//   press pulses per button, and a one-cycle "something changed" pulse.
//
//   Optional feature macro: AUTOREPEAT_EN
//     defined   -> a held button re-pulses every REPEAT_CYCLES cycles
//     undefined -> exactly one pulse per press, no repeat counters exist
module board_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 8,
  parameter int unsigned N_SW            = 4,
  parameter int unsigned N_BTN           = 3
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [N_SW-1:0]  switches_raw_i,
  input  logic [N_BTN-1:0] buttons_raw_i,
  output logic [N_SW-1:0]  switches_o,
  output logic [N_BTN-1:0] buttons_o,
  output logic [N_BTN-1:0] button_pulse_o,
  output logic             input_changed_o
);

  // Switches and buttons share one filter path; buttons occupy the upper bits.
  localparam int unsigned N_IN  = N_SW + N_BTN;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  rawAll;
  logic [N_IN-1:0]  sync1_q;
  logic [N_IN-1:0]  sync2_q;
  logic [N_IN-1:0]  stable_q;
  logic [N_IN-1:0]  stable_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [N_IN-1:0]  accept;

  logic [N_BTN-1:0] btnStable;
  logic [N_BTN-1:0] btnAccept;
  logic [N_BTN-1:0] btnRise;
  logic [N_BTN-1:0] pulse_q;
  logic [N_BTN-1:0] pulse_d;
  logic             changed_q;
  logic             changed_d;

  assign rawAll = {buttons_raw_i, switches_raw_i};

  // Two-flop synchronizer per bit; only the second stage feeds the filter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawAll;
      sync2_q <= sync1_q;
    end
  end

  // Debounce filter: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i]   = 1'b1;
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state: accepted levels and per-bit disagreement counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stable_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btnStable = stable_q[N_IN-1:N_SW];
  assign btnAccept = accept[N_IN-1:N_SW];
  assign btnRise   = btnAccept & sync2_q[N_IN-1:N_SW];
  assign changed_d = |accept;

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q [N_BTN];
  logic [REP_W-1:0] rep_d [N_BTN];
  logic [N_BTN-1:0] repFire;

  // Repeat timer: runs only while a button stays accepted as pressed, and is
  // zero on the press edge and on release so each hold starts a fresh period.
  always_comb begin
    repFire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_d[i] = '0;
      if (btnStable[i] && !btnAccept[i]) begin
        if (rep_q[i] == REP_LAST) begin
          repFire[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
    end
    pulse_d = btnRise | repFire;
  end

  // Repeat timer registers, one per button.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rep_q[i] <= rep_d[i];
      end
    end
  end
`else
  // Without auto-repeat a press pulses only on its accepted rising edge.
  always_comb begin
    pulse_d = btnRise;
  end
`endif

  // Pulse outputs are registered so they line up with the new stable levels.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pulse_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      pulse_q   <= pulse_d;
      changed_q <= changed_d;
    end
  end

  assign switches_o      = stable_q[N_SW-1:0];
  assign buttons_o       = btnStable;
  assign button_pulse_o  = pulse_q;
  assign input_changed_o = changed_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner
//   Directed bench for board_input_conditioner at DEBOUNCE_CYCLES=4,
//   REPEAT_CYCLES=8. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so "tick k" below means the
//   values visible just after the k-th rising edge following a step.
module tb_board_input_conditioner;

  logic       clk;
  logic       resetN;
  logic [3:0] switchesRaw;
  logic [2:0] buttonsRaw;
  logic [3:0] switches;
  logic [2:0] buttons;
  logic [2:0] buttonPulse;
  logic       inputChanged;

  int errorCount;
  int checkCount;

`ifdef AUTOREPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  board_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8),
    .N_SW           (4),
    .N_BTN          (3)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (resetN),
    .switches_raw_i (switchesRaw),
    .buttons_raw_i  (buttonsRaw),
    .switches_o     (switches),
    .buttons_o      (buttons),
    .button_pulse_o (buttonPulse),
    .input_changed_o(inputChanged)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the raw switch and button levels.
  task automatic applyStimulus(input logic [3:0] sw, input logic [2:0] btn);
    switchesRaw = sw;
    buttonsRaw  = btn;
  endtask

  // Advances to 1 unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;

    // Test 1: reset with all raw inputs high, then a switch step.
    resetN = 1'b0;
    applyStimulus(4'b1111, 3'b111);
    #1;
    checkOutput("rst_async_switches", 32'(switches), 32'h0);
    tick();
    tick();
    checkOutput("rst_switches", 32'(switches), 32'h0);
    checkOutput("rst_buttons", 32'(buttons), 32'h0);
    checkOutput("rst_pulse", 32'(buttonPulse), 32'h0);
    checkOutput("rst_changed", 32'(inputChanged), 32'h0);

    resetN = 1'b1;
    applyStimulus(4'b1000, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        checkOutput("t1_sw_edge5", 32'(switches), 32'h0);
        checkOutput("t1_chg_edge5", 32'(inputChanged), 32'h0);
      end
      if (k == 6) begin
        checkOutput("t1_sw_edge6", 32'(switches), 32'h8);
        checkOutput("t1_chg_edge6", 32'(inputChanged), 32'h1);
        checkOutput("t1_btn_edge6", 32'(buttons), 32'h0);
      end
      if (k == 7) begin
        checkOutput("t1_sw_edge7", 32'(switches), 32'h8);
        checkOutput("t1_chg_edge7", 32'(inputChanged), 32'h0);
      end
    end

    // Test 2: a 3-cycle button glitch must be rejected.
    applyStimulus(4'b1000, 3'b010);
    tick();
    tick();
    tick();
    applyStimulus(4'b1000, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput("t2_glitch_quiet", {22'h0, buttons, buttonPulse, switches, inputChanged},
                  {22'h0, 3'b000, 3'b000, 4'b1000, 1'b0});
    end

    // Test 3: two buttons pressed for 10 cycles, then released.
    applyStimulus(4'b1000, 3'b110);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        checkOutput("t3_btn_edge5", 32'(buttons), 32'h0);
        checkOutput("t3_pulse_edge5", 32'(buttonPulse), 32'h0);
      end
      if (k == 6) begin
        checkOutput("t3_btn_edge6", 32'(buttons), 32'h6);
        checkOutput("t3_pulse_edge6", 32'(buttonPulse), 32'h6);
        checkOutput("t3_chg_edge6", 32'(inputChanged), 32'h1);
      end
      if (k == 7) begin
        checkOutput("t3_pulse_edge7", 32'(buttonPulse), 32'h0);
        checkOutput("t3_chg_edge7", 32'(inputChanged), 32'h0);
      end
    end
    applyStimulus(4'b1000, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        checkOutput("t3_rel_btn_edge5", 32'(buttons), 32'h6);
        checkOutput("t3_rel_pulse_edge5", 32'(buttonPulse), 32'h0);
      end
      if (k == 6) begin
        checkOutput("t3_rel_btn_edge6", 32'(buttons), 32'h0);
        checkOutput("t3_rel_pulse_edge6", 32'(buttonPulse), 32'h0);
        checkOutput("t3_rel_chg_edge6", 32'(inputChanged), 32'h1);
      end
      if (k == 7) begin
        checkOutput("t3_rel_pulse_edge7", 32'(buttonPulse), 32'h0);
      end
    end

    // Test 4: reset in the middle of a count discards partial progress.
    applyStimulus(4'b1000, 3'b001);
    tick();
    tick();
    tick();
    resetN = 1'b0;
    #1;
    checkOutput("t4_rst_switches", 32'(switches), 32'h0);
    checkOutput("t4_rst_buttons", 32'(buttons), 32'h0);
    tick();
    tick();
    checkOutput("t4_rst_held_all", {25'h0, buttons, buttonPulse, inputChanged}, 32'h0);
    resetN = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checkOutput("t4_btn_edge5", 32'(buttons), 32'h0);
      end
      if (k == 6) begin
        checkOutput("t4_btn_edge6", 32'(buttons), 32'h1);
        checkOutput("t4_pulse_edge6", 32'(buttonPulse), 32'h1);
        checkOutput("t4_sw_edge6", 32'(switches), 32'h8);
        checkOutput("t4_chg_edge6", 32'(inputChanged), 32'h1);
      end
    end

    // Test 5: clear everything, then step a switch and a button together.
    applyStimulus(4'b0000, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
    end
    checkOutput("t5_cleared", {25'h0, switches, buttons}, 32'h0);
    applyStimulus(4'b0001, 3'b001);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) begin
        checkOutput("t5_both_edge5", {25'h0, switches, buttons}, 32'h0);
      end
      if (k == 6) begin
        checkOutput("t5_sw_edge6", 32'(switches), 32'h1);
        checkOutput("t5_btn_edge6", 32'(buttons), 32'h1);
        checkOutput("t5_pulse_edge6", 32'(buttonPulse), 32'h1);
        checkOutput("t5_chg_edge6", 32'(inputChanged), 32'h1);
      end
      if (k == 7) begin
        checkOutput("t5_chg_edge7", 32'(inputChanged), 32'h0);
        checkOutput("t5_pulse_edge7", 32'(buttonPulse), 32'h0);
      end
    end

    // Test 6: hold button 2 for 30 cycles; pulses repeat only with auto-repeat.
    applyStimulus(4'b0001, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
    end
    applyStimulus(4'b0001, 3'b100);
    for (int k = 1; k <= 40; k++) begin
      logic [2:0] expPulse;
      logic       expChanged;
      tick();
      expPulse   = 3'b000;
      expChanged = 1'b0;
      if (k == 6) begin
        expPulse   = 3'b100;
        expChanged = 1'b1;
      end
      if (AUTO_REPEAT && (k == 14 || k == 22 || k == 30)) begin
        expPulse = 3'b100;
      end
      if (k == 36) begin
        expChanged = 1'b1;
      end
      checkOutput($sformatf("t6_pulse_k%0d", k), 32'(buttonPulse), 32'(expPulse));
      checkOutput($sformatf("t6_chg_k%0d", k), 32'(inputChanged), 32'(expChanged));
      if (k == 30) begin
        applyStimulus(4'b0001, 3'b000);
      end
    end
    checkOutput("t6_btn_released", 32'(buttons), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
